// File: rtl/twos_comp_serial.sv
// Bit-serial two's-complement pass / negate / absolute-value unit, LSB first.
// Result valid WIDTH cycles after accept; result held in DONE until out_ready.
module twos_comp_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             a_bit;
  logic             sum_bit;
  logic             carry_nxt;
  logic             neg_acc;

  // Single full-adder slice: adding the carry to the inverted bit gives -A.
  assign a_bit     = a_q[0];
  assign sum_bit   = neg_q ? (~a_bit ^ carry_q) : a_bit;
  assign carry_nxt = ~a_bit & carry_q;
  assign neg_acc   = (mode == 2'b01) || ((mode == 2'b10) && A[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          neg_d   = neg_acc;
          carry_d = neg_acc;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        a_d     = a_q >> 1;
        y_d     = {sum_bit, y_q[WIDTH-1:1]};
        carry_d = neg_q & carry_nxt;
        if (cnt_q == LAST) begin
          // Carry still set at the MSB means every lower bit was zero.
          ovf_d   = neg_q & carry_q & a_bit;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign Y         = y_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_twos_comp_serial.sv
// Directed and randomized checks of twos_comp_serial (WIDTH=8) against an
// arithmetic reference model.
module tb_twos_comp_serial;

  localparam int W = 8;
  localparam logic [W-1:0] MIN_NEG = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [1:0]   mode = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Y;
  logic         overflow;
  logic         busy;

  int n_asrt = 0;
  int n_fail = 0;

  twos_comp_serial #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y        (Y),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [1:0] m,
                                output logic [W-1:0] y, output logic o);
    bit neg;
    neg = (m == 2'b01) || (m == 2'b10 && $signed(a) < 0);
    y   = neg ? W'(0 - a) : a;
    o   = neg && (a == MIN_NEG);
  endfunction

  // One full transaction: accept, latency, stall in DONE, handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [1:0] m,
                        input int stall, input logic [W-1:0] exp_y, input logic exp_o);
    int cyc;
    chk({tag, ".in_ready_pre"}, in_ready, 1);
    A = a; mode = m; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    A = W'($urandom);
    mode = 2'($urandom);
    chk({tag, ".busy"}, {in_ready, busy}, 2'b01);
    cyc = 1;
    while (!out_valid && cyc < 4 * W) begin
      tick();
      if (!out_valid) cyc++;
    end
    chk({tag, ".latency"}, cyc, W);
    chk({tag, ".y"}, Y, exp_y);
    chk({tag, ".ovf"}, overflow, exp_o);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      A = W'($urandom);
      tick();
      chk({tag, ".stall"}, {out_valid, in_ready, overflow, Y}, {1'b1, 1'b0, exp_o, exp_y});
    end
    in_valid = 1'($urandom);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({tag, ".post_hs"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [W-1:0] ry, a;
    logic [1:0]   m;
    logic         ro;
    bit           seen;

    tick();
    tick();
    reset = 1'b0;
    chk("reset", {in_ready, out_valid, busy, overflow, Y}, {4'b1000, {W{1'b0}}});

    run_op("neg05", 8'h05, 2'b01, 0, 8'hFB, 1'b0);
    run_op("neg80", 8'h80, 2'b01, 0, 8'h80, 1'b1);
    run_op("neg00", 8'h00, 2'b01, 1, 8'h00, 1'b0);
    run_op("absFB", 8'hFB, 2'b10, 0, 8'h05, 1'b0);
    run_op("abs7F", 8'h7F, 2'b10, 2, 8'h7F, 1'b0);
    run_op("abs80", 8'h80, 2'b10, 0, 8'h80, 1'b1);
    run_op("passA5", 8'hA5, 2'b00, 0, 8'hA5, 1'b0);
    run_op("rsvdA5", 8'hA5, 2'b11, 0, 8'hA5, 1'b0);
    run_op("bp", 8'h3C, 2'b01, 5, 8'hC4, 1'b0);

    // Reset after three bits of a negate: operation must vanish.
    A = 8'h05; mode = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset", {in_ready, out_valid, busy, Y}, {3'b100, {W{1'b0}}});
    seen = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midreset.no_out", seen, 0);
    run_op("neg01", 8'h01, 2'b01, 0, 8'hFF, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      if (i % 16 == 0) a = MIN_NEG;
      m = 2'($urandom_range(0, 3));
      model(a, m, ry, ro);
      run_op("rand", a, m, $urandom_range(0, 3), ry, ro);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/twos_comp_serial.md
TWOS_COMP_SERIAL -- requirements
Module: twos_comp_serial

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  system clock; all state changes on rising edge; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  operand and mode on A/mode are valid.
REQ-005 in_ready  output  1  block can accept an operand (high only in IDLE).
REQ-006 A  input  WIDTH  two's-complement operand.
REQ-007 mode  input  2  00 pass, 01 negate, 10 absolute value, 11 reserved (treated as pass).
REQ-008 out_valid  output  1  result/overflow valid (high only in DONE).
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 Y  output  WIDTH  result.
REQ-011 overflow  output  1  result not representable in WIDTH bits.
REQ-012 busy  output  1  high in BUSY state.

Function
REQ-013 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready, latch A into operand shift register, latch mode, clear bit counter, go BUSY.
REQ-015 Mode 10 resolved at accept: negate if A[WIDTH-1]=1, else pass; mode 11 resolved as pass.
REQ-016 BUSY: process exactly one bit per cycle, LSB first, using one full-adder slice plus a 1-bit carry register.
REQ-017 Negate path: carry initialised to 1 at accept; per bit y_i = ~a_i XOR c, c_next = ~a_i AND c (invert-and-add-one).
REQ-018 Pass path: y_i = a_i; carry ignored.
REQ-019 Result bits shift into Y register from MSB end; Y holds the complete result only on entering DONE.
REQ-020 Bit counter counts 0..WIDTH-1; after the cycle processing bit WIDTH-1, go DONE.
REQ-021 Latency: out_valid rises exactly WIDTH clock cycles after the accepting edge.
REQ-022 overflow=1 iff effective operation is negate and latched A = 1 followed by WIDTH-1 zeros; Y then equals A.
REQ-023 Negating zero: Y=0, overflow=0.
REQ-024 DONE: out_valid=1; Y and overflow held stable until out_valid&&out_ready; then go IDLE.
REQ-025 Handshake at DONE->IDLE costs one cycle; in_ready rises the cycle after the output handshake (no same-cycle accept).
REQ-026 in_valid, A, mode ignored in BUSY and DONE; changes to A after accept do not affect the result.
REQ-027 out_ready ignored outside DONE.
REQ-028 Y and overflow values outside DONE are don't-care to downstream but SHALL not be X after reset.

Reset
REQ-029 reset has priority over all other inputs in any state, including mid-BUSY and DONE.
REQ-030 After reset edge: state IDLE, in_ready=1, out_valid=0, busy=0, Y=0, overflow=0, counter=0, carry=0.
REQ-031 Operation in progress at reset is discarded; no out_valid is produced for it.

Verification (WIDTH=8)
REQ-032 Negate: A=0x05, mode=01, out_ready=1 -> out_valid exactly 8 cycles after accept, Y=0xFB, overflow=0.
REQ-033 Corner: A=0x80, mode=01 -> Y=0x80, overflow=1; A=0x00, mode=01 -> Y=0x00, overflow=0.
REQ-034 Abs/pass: A=0xFB, mode=10 -> Y=0x05; A=0x7F, mode=10 -> Y=0x7F; A=0xA5, mode=00 and mode=11 -> Y=0xA5; all overflow=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE, toggle A/in_valid meanwhile -> Y, overflow, out_valid stable, in_ready=0; result consumed on first out_ready=1 cycle, in_ready=1 next cycle.
REQ-036 Reset mid-operation: assert reset after 3 bits of A=0x05 negate -> next cycle IDLE, Y=0, out_valid=0, in_ready=1; fresh A=0x01 mode=01 then yields Y=0xFF.
REQ-037 Random: 1000 random A/mode with random out_ready stalls, checked against a reference model, plus WIDTH=2 and WIDTH=32 builds.
